// File: rtl/secure_regfile_pkg.sv
// rtl/secure_regfile_pkg.sv - shared types, defaults and slice helper for secure_regfile
package secure_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIPE = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int rd_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/secure_regfile_if.sv
// rtl/secure_regfile_if.sv - read/write/zeroize bus for secure_regfile
interface secure_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_sel;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_sel;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W-1:0]        dest_data;
    logic                     zeroize_req;
    logic                     zeroize_busy;
    logic                     zeroize_done;
    logic [NUM_RD-1:0]        parity_err;

    modport master (
        output rd_en, rd_sel, wr_en, wr_sel, wr_data, zeroize_req,
        input  rd_data, dest_data, zeroize_busy, zeroize_done, parity_err
    );

    modport slave (
        input  rd_en, rd_sel, wr_en, wr_sel, wr_data, zeroize_req,
        output rd_data, dest_data, zeroize_busy, zeroize_done, parity_err
    );
endinterface

// File: rtl/secure_regfile_zeroize_fsm.sv
// rtl/secure_regfile_zeroize_fsm.sv - sequential wipe sequencer, IDLE -> WIPE (DEPTH cycles) -> DONE
module regfile_zeroize_fsm
    import secure_regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              dpclk,
    input  logic              rst,
    input  logic              req,
    output logic              wipe_en,
    output logic [ADDR_W-1:0] wipe_addr,
    output logic              busy,
    output logic              done
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt, cnt_next;

    // busy/done are registered from next_state so they line up with the state register
    always_ff @(posedge dpclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = WIPE;
                    cnt_next   = '0;
                end
            end
            WIPE: begin
                if (cnt == '1) next_state = DONE;
                else           cnt_next   = cnt + 1'b1;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign wipe_en   = (state == WIPE);
    assign wipe_addr = cnt;

endmodule

// File: rtl/secure_regfile.sv
// rtl/secure_regfile.sv - multi-port register file with bypass, hardwired r0, zeroize; optional parity via REGFILE_PARITY_EN
module secure_regfile
    import secure_regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic             dpclk,
    input  logic             rst,
    secure_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q   [NUM_RD];
    logic [DATA_W-1:0] rd_nxt [NUM_RD];
    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [NUM_RD-1:0] rd_live, rd_byp;
    logic              wipe_en, busy, done, wr_ok;
    logic [ADDR_W-1:0] wipe_addr;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG0 != 0) && (a == '0);
    endfunction

    regfile_zeroize_fsm #(.ADDR_W(ADDR_W)) u_zeroize (
        .dpclk     (dpclk),
        .rst       (rst),
        .req       (bus.zeroize_req),
        .wipe_en   (wipe_en),
        .wipe_addr (wipe_addr),
        .busy      (busy),
        .done      (done)
    );

    assign bus.zeroize_busy = busy;
    assign bus.zeroize_done = done;
    // busy is low exactly when the sequencer sits in IDLE
    assign wr_ok = bus.wr_en && !busy && !is_zero_reg(bus.wr_sel);

    always_ff @(posedge dpclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wipe_en) begin
            mem[wipe_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_sel] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_addr = '{default: '0};
        rd_nxt  = '{default: '0};
        rd_live = '0;
        rd_byp  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = bus.rd_sel[rd_off(k, ADDR_W) +: ADDR_W];
            rd_live[k] = bus.rd_en[k] && !busy && !is_zero_reg(rd_addr[k]);
            rd_byp[k]  = bus.wr_en && (bus.wr_sel == rd_addr[k]);
            if (rd_live[k]) rd_nxt[k] = rd_byp[k] ? bus.wr_data : mem[rd_addr[k]];
        end
    end

    always_ff @(posedge dpclk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_RD; k++) rd_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) rd_q[k] <= rd_nxt[k];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) bus.rd_data[rd_off(k, DATA_W) +: DATA_W] = rd_q[k];
    end

    assign bus.dest_data = is_zero_reg(bus.wr_sel) ? '0 : mem[bus.wr_sel];

`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0]  par;
    logic [NUM_RD-1:0] perr_nxt, perr_q;

    always_ff @(posedge dpclk or negedge rst) begin
        if (!rst) begin
            par <= '0;
        end else if (wipe_en) begin
            par[wipe_addr] <= 1'b0;
        end else if (wr_ok) begin
            par[bus.wr_sel] <= ^bus.wr_data;
        end
    end

    // bypassed data never touched storage, so it cannot carry a storage error
    always_comb begin
        perr_nxt = '0;
        for (int k = 0; k < NUM_RD; k++)
            perr_nxt[k] = rd_live[k] && !rd_byp[k] && ((^mem[rd_addr[k]]) != par[rd_addr[k]]);
    end

    always_ff @(posedge dpclk or negedge rst) begin
        if (!rst) perr_q <= '0;
        else      perr_q <= perr_nxt;
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = '0;
`endif

endmodule

// File: doc/secure_regfile.md
Name: secure_regfile

Overview:
- Parametrised multi-port register file for the datapath; successor to the 32x32, two-read-port datapath register array.
- Configurable width, depth and read-port count. Reads are registered, with write-to-read bypass.
- Optional hardwired-zero register 0.
- Hardware zeroize state machine sequentially wipes every register on request (secure context clear), with busy/done handshake.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, select width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, number of read ports
- ZERO_REG0, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
- dpclk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_sel  in  NUM_RD*ADDR_W  per-port read select, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  per-port registered read data, port k at [k*DATA_W +: DATA_W]
- wr_en  in  1  write strobe
- wr_sel  in  ADDR_W  write select
- wr_data  in  DATA_W  write data
- dest_data  out  DATA_W  combinational current contents of register wr_sel
- zeroize_req  in  1  request full wipe, level-sampled
- zeroize_busy  out  1  wipe in progress; writes ignored
- zeroize_done  out  1  one-cycle pulse at wipe completion
- parity_err  out  NUM_RD  per-port parity error, aligned with rd_data

Behaviour:
- Reset (rst=0, async):
  - all registers, rd_data, zeroize_busy, zeroize_done and parity_err go to 0
  - FSM goes to IDLE; wipe counter goes to 0
- Write (IDLE only): on an edge with wr_en=1, mem[wr_sel] <= wr_data. Exception: when ZERO_REG0=1 and wr_sel=0, the write is dropped.
- Read, per port k, latency 1 cycle. At each edge rd_data_k <=:
  - 0 if rd_en_k=0, or state is not IDLE, or (ZERO_REG0=1 and rd_sel_k=0)
  - else wr_data if wr_en=1 and wr_sel=rd_sel_k (bypass: the same-cycle write is visible)
  - else mem[rd_sel_k]
- Multiple ports may select the same register; each gets identical data.
- dest_data = mem[wr_sel], combinational, no bypass. It is 0 for register 0 when ZERO_REG0=1.
- FSM states IDLE, WIPE, DONE:
  - IDLE -> WIPE when zeroize_req=1 at an edge; counter is set to 0. Any write presented at that same edge still completes and is then wiped.
  - WIPE: each cycle mem[cnt] <= 0 and cnt increments. When cnt=DEPTH-1 has been cleared, go to DONE. Counter width is ADDR_W; no wrap is ever taken.
  - DONE: one cycle, then -> IDLE.
- Outputs are state-decoded and registered: zeroize_busy=1 in WIPE and DONE; zeroize_done=1 in DONE only.
- Busy duration is DEPTH+1 cycles (33 at default). The first post-wipe write is accepted in the first IDLE cycle.
- zeroize_req while busy is ignored; it is not queued. If still high in the first IDLE cycle, a new wipe starts.
- wr_en during WIPE/DONE is ignored; no error is flagged.
- Reset asserted mid-wipe: immediate return to IDLE with all registers 0.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - each register stores an extra even-parity bit (^wr_data), written on write; zeroize writes parity 0
  - on each read, parity_err_k <= rd_en_k & state==IDLE & (^stored_word != stored_parity), registered with rd_data_k
  - bypassed reads and reads of the hardwired register 0 report 0
  - the bench uses a force on a storage bit to inject errors
- Undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Package secure_regfile_pkg:
  - FSM state enum: IDLE=2'd0, WIPE=2'd1, DONE=2'd2
  - DATA_W/ADDR_W defaults
  - function for read-port slice offsets
- One sub-module is natural: regfile_zeroize_fsm. It owns the state and counter and outputs wipe_en, wipe_addr, busy, done.
- Storage array, read muxes and bypass stay in the top.

Test Plan:
- Write 0xDEADBEEF to r5; next cycle read r5 on port 0 with rd_en=1 -> rd_data port 0 = 0xDEADBEEF one cycle later; dest_data with wr_sel=5 = 0xDEADBEEF.
- Same-cycle write 0x12345678 to r7 while both ports read r7 -> both ports show 0x12345678 after 1 cycle (bypass).
- ZERO_REG0=1: write 0xFFFFFFFF to r0, then read r0 -> 0; rd_en=0 on any port -> that port reads 0.
- Fill r1..r31 with index*0x01010101, pulse zeroize_req one cycle:
  - zeroize_busy high exactly 33 cycles, zeroize_done high on the 33rd only
  - writes during busy are dropped; reads during busy return 0
  - afterwards all registers read 0
- Assert rst low in WIPE at cnt=10 -> all outputs 0 immediately, FSM IDLE; a write to r3 after reset release succeeds.
- REGFILE_PARITY_EN: write 0x00000001 to r4, force-flip bit 0 in storage, read r4 -> parity_err port 0 = 1 in the same cycle as rd_data; unflipped r6 read -> 0.
